// File: rtl/bk_sum_stage.sv
// bk_sum_stage: final sum stage of a Brent-Kung adder.
// Folds the carry-in into the prefix-tree group generate/propagate terms,
// forms sum/cout/signed overflow, and registers the result through a
// 2-entry skid buffer with valid/ready handshakes on both sides.
// The head entry drives the outputs directly, so an accepted word appears
// one cycle after acceptance when the buffer was empty.
// Optional feature: define BK_SUM_STATS_EN to add the saturating 16-bit
// carry_cnt output counting output transfers that carry cout = 1.
module bk_sum_stage #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] p_in,
    input  logic [N-1:0] gg_in,
    input  logic [N-1:0] gp_in,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         out_valid,
    input  logic         out_ready
`ifdef BK_SUM_STATS_EN
    ,
    output logic [15:0]  carry_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Result word layout: {cout, ovf, sum[N-1:0]}.
    localparam int W = N + 2;

    // Full carries are c[i] = G[i:0] | (P[i:0] & cin); sum bit i uses the
    // carry into bit i, which is cin for bit 0 and c[i-1] above that.
    function automatic logic [W-1:0] finish_sum(
        input logic [N-1:0] p,
        input logic [N-1:0] gg,
        input logic [N-1:0] gp,
        input logic         ci
    );
        logic [N-1:0] c;
        logic [N-1:0] s;
        c = gg | (gp & {N{ci}});
        s = p ^ {c[N-2:0], ci};
        return {c[N-1], c[N-1] ^ c[N-2], s};
    endfunction

    state_t         state;
    logic [W-1:0]   word;
    logic [N-1:0]   skid_sum;
    logic           skid_cout;
    logic           skid_ovf;
    logic           accept;
    logic           drain;

    // Combinational finishing of the incoming word and handshake qualifiers.
    always_comb begin
        word   = finish_sum(p_in, gg_in, gp_in, cin);
        accept = in_valid & in_ready;
        drain  = out_valid & out_ready;
    end

    // Skid-buffer FSM: head entry drives outputs, skid entry holds the
    // second word; in_ready is registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= {N{1'b0}};
            cout      <= 1'b0;
            ovf       <= 1'b0;
            skid_sum  <= {N{1'b0}};
            skid_cout <= 1'b0;
            skid_ovf  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        {cout, ovf, sum} <= word;
                        out_valid        <= 1'b1;
                        state            <= ONE;
                    end else begin
                        state <= EMPTY;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        {cout, ovf, sum} <= word;
                        in_ready         <= 1'b1;
                        state            <= ONE;
                    end else if (accept) begin
                        {skid_cout, skid_ovf, skid_sum} <= word;
                        in_ready                        <= 1'b0;
                        state                           <= FULL;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= EMPTY;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                FULL: begin
                    if (drain) begin
                        sum      <= skid_sum;
                        cout     <= skid_cout;
                        ovf      <= skid_ovf;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end else begin
                        in_ready <= 1'b0;
                        state    <= FULL;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to an empty buffer.
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

`ifdef BK_SUM_STATS_EN
    // Saturating count of output transfers whose word carries cout = 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_cnt <= 16'h0000;
        end else if (drain && cout && (carry_cnt != 16'hFFFF)) begin
            carry_cnt <= carry_cnt + 16'h0001;
        end else begin
            carry_cnt <= carry_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_bk_sum_stage.sv
// Directed testbench for bk_sum_stage at N = 8 with hand-computed vectors.
// Define BK_SUM_STATS_EN to also exercise carry_cnt saturation.
module tb_bk_sum_stage;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] p_in;
    logic [N-1:0] gg_in;
    logic [N-1:0] gp_in;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         out_valid;
    logic         out_ready;
`ifdef BK_SUM_STATS_EN
    logic [15:0]  carry_cnt;
`endif

    int errors;
    int checks;

    bk_sum_stage #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p_in      (p_in),
        .gg_in     (gg_in),
        .gp_in     (gp_in),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef BK_SUM_STATS_EN
        ,
        .carry_cnt (carry_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] p, input logic [N-1:0] gg,
                         input logic [N-1:0] gp, input logic c);
        in_valid = v;
        p_in     = p;
        gg_in    = gg;
        gp_in    = gp;
        cin      = c;
    endtask

    task automatic chk_out(input string tag, input logic [N-1:0] s, input logic co, input logic ov);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_sum"},   {24'd0, sum},       {24'd0, s});
        chk({tag, "_cout"},  {31'd0, cout},      {31'd0, co});
        chk({tag, "_ovf"},   {31'd0, ovf},       {31'd0, ov});
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        #1;
        // Reset state
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready},  32'd0);
        chk("rst_sum",   {24'd0, sum},       32'd0);
        chk("rst_cout",  {31'd0, cout},      32'd0);
        chk("rst_ovf",   {31'd0, ovf},       32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rel_ready_pre", {31'd0, in_ready}, 32'd0);
        tick();
        chk("rel_ready", {31'd0, in_ready}, 32'd1);

        // Arithmetic vectors, back to back with out_ready = 1
        out_ready = 1'b1;
        drive(1'b1, 8'h7E, 8'h7F, 8'h00, 1'b0);
        tick();
        chk_out("v1", 8'h80, 1'b0, 1'b1);
        drive(1'b1, 8'hFF, 8'h00, 8'hFF, 1'b1);
        tick();
        chk_out("v2", 8'h00, 1'b1, 1'b0);
        drive(1'b1, 8'h00, 8'h80, 8'h00, 1'b1);
        tick();
        chk_out("v3", 8'h01, 1'b1, 1'b1);
        drive(1'b1, 8'h0F, 8'h00, 8'h0F, 1'b1);
        tick();
        chk_out("v4", 8'h10, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        chk("drain_empty", {31'd0, out_valid}, 32'd0);
        chk("drain_ready", {31'd0, in_ready},  32'd1);

        // Backpressure: three words offered while out_ready = 0
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 8'h00, 8'h00, 1'b0);
        tick();
        chk_out("bp_a", 8'h11, 1'b0, 1'b0);
        chk("bp_a_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 8'h22, 8'h00, 8'h00, 1'b0);
        tick();
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_full_sum", {24'd0, sum}, 32'h11);
        drive(1'b1, 8'h33, 8'h00, 8'h00, 1'b0);
        tick();
        chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        chk_out("bp_hold", 8'h11, 1'b0, 1'b0);
        tick();
        chk("bp_hold2_sum", {24'd0, sum}, 32'h11);
        out_ready = 1'b1;
        tick();
        chk_out("bp_b", 8'h22, 1'b0, 1'b0);
        chk("bp_b_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk_out("bp_c", 8'h33, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Streaming: 10 words, one per cycle, in order
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(8'h05 + 8'(i * 7)), 8'h00, 8'h00, 1'b0);
            tick();
            chk_out("stream", 8'(8'h05 + 8'(i * 7)), 1'b0, 1'b0);
            chk("stream_ready", {31'd0, in_ready}, 32'd1);
        end
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        chk("stream_empty", {31'd0, out_valid}, 32'd0);

        // Reset while FULL discards buffered words
        out_ready = 1'b0;
        drive(1'b1, 8'h44, 8'h00, 8'h00, 1'b0);
        tick();
        drive(1'b1, 8'h55, 8'h00, 8'h00, 1'b0);
        tick();
        chk("pre_rst_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready},  32'd0);
        chk("mid_rst_sum",   {24'd0, sum},       32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        drive(1'b1, 8'h66, 8'h00, 8'h00, 1'b0);
        tick();
        chk_out("post_rst_w", 8'h66, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        chk("post_rst_empty", {31'd0, out_valid}, 32'd0);
        tick();
        chk("post_rst_empty2", {31'd0, out_valid}, 32'd0);

`ifdef BK_SUM_STATS_EN
        // Carry counter saturation over 0x10000 carry-producing transfers
        chk("cnt_zero", {16'd0, carry_cnt}, 32'd0);
        for (int i = 0; i < 65536; i++) begin
            drive(1'b1, 8'hFF, 8'h00, 8'hFF, 1'b1);
            tick();
        end
        chk("cnt_near", {16'd0, carry_cnt}, 32'h0000FFFF);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        chk("cnt_sat", {16'd0, carry_cnt}, 32'h0000FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bk_sum_stage.md
BK_SUM_STAGE -- requirements
Module: bk_sum_stage

Interface
REQ-001 SHALL have parameter N, default 16, meaning operand width; legal values are powers of two >= 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream prefix-stage word valid.
REQ-005 SHALL have port in_ready  output  1  stage can accept a word this cycle.
REQ-006 SHALL have port p_in  input  N  bitwise propagate, a[i]^b[i].
REQ-007 SHALL have port gg_in  input  N  group generate G[i:0] from the prefix tree, computed without carry-in.
REQ-008 SHALL have port gp_in  input  N  group propagate P[i:0] from the prefix tree.
REQ-009 SHALL have port cin  input  1  adder carry-in, qualified by in_valid.
REQ-010 SHALL have port sum  output  N  registered sum.
REQ-011 SHALL have port cout  output  1  registered carry-out of bit N-1.
REQ-012 SHALL have port ovf  output  1  registered signed-overflow flag.
REQ-013 SHALL have port out_valid  output  1  sum/cout/ovf valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the word.

Function
REQ-015 SHALL compute the full carry as c[i] = gg_in[i] | (gp_in[i] & cin) for i = 0..N-1.
REQ-016 SHALL compute sum[0] = p_in[0]^cin and sum[i] = p_in[i]^c[i-1] for i >= 1.
REQ-017 SHALL set cout = c[N-1] and ovf = c[N-1]^c[N-2].
REQ-018 SHALL capture a word when in_valid && in_ready; both sides use a valid/ready handshake, with transfer on valid && ready at a rising edge.
REQ-019 SHALL hold a 2-entry skid buffer with states EMPTY, ONE and FULL.
REQ-020 SHALL set in_ready = 1 in EMPTY and ONE, and in_ready = 0 in FULL; in_ready SHALL be registered and SHALL NOT depend combinationally on out_ready.
REQ-021 SHALL apply these state transitions:
  - EMPTY -> ONE on accept.
  - ONE -> EMPTY on drain without accept.
  - ONE stays ONE on simultaneous accept and drain.
  - ONE -> FULL on accept without drain.
  - FULL -> ONE on drain.
REQ-022 SHALL deliver an accepted word on out_* at the edge following acceptance when the buffer was EMPTY, giving 1-cycle latency.
REQ-023 SHALL keep out_valid = 1 with sum/cout/ovf stable until out_ready is seen while out_valid is high.
REQ-024 SHALL present words in strict FIFO order; no word is dropped or duplicated.
REQ-025 SHALL leave the state unchanged when in_valid = 1 in FULL; the word is not accepted.

Reset
REQ-026 SHALL, while rst is high, immediately force state = EMPTY, out_valid = 0, in_ready = 0, sum = 0, cout = 0 and ovf = 0.
REQ-027 SHALL raise in_ready to 1 on the first rising clk edge after rst deasserts.
REQ-028 SHALL discard all buffered words when reset is asserted mid-operation; no output is produced for them after reset.

Configuration
REQ-029 SHALL, when macro BK_SUM_STATS_EN is defined, add output port carry_cnt (16 bits):
  - counts output transfers with cout = 1;
  - saturates at 0xFFFF;
  - resets to 0.
REQ-030 SHALL, when BK_SUM_STATS_EN is undefined, omit carry_cnt and all counting logic; all other behaviour is identical.

Verification (N=8)
REQ-031 SHALL cover: p_in=0x7E, gg_in=0x7F, gp_in=0x00, cin=0, out_ready=1 -> next cycle sum=0x80, cout=0, ovf=1, out_valid=1.
REQ-032 SHALL cover: p_in=0xFF, gg_in=0x00, gp_in=0xFF, cin=1 -> sum=0x00, cout=1, ovf=0.
REQ-033 SHALL cover: out_ready=0 with 3 words offered -> after 2 accepts in_ready=0; the third word is held upstream; out_* holds the first word unchanged.
REQ-034 SHALL cover: continuous in_valid=1 and out_ready=1 for 10 words -> one word per cycle, same order, in_ready constantly 1.
REQ-035 SHALL cover: rst pulsed while FULL -> out_valid=0 immediately; the subsequent first output is the first post-reset word.
REQ-036 SHALL cover: with BK_SUM_STATS_EN defined, 0x10000 carry-producing transfers -> carry_cnt=0xFFFF.
